// File: rtl/scene_render.sv
// VGA 640x480 scene renderer: sync timing, layered sprites/walls and a BCD score.
// Define SCENE_SNAPSHOT_EN to latch scene inputs at vblank for tear-free frames.
module scene_render (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  ay,
  input  logic [9:0]  by,
  input  logic [9:0]  cy,
  input  logic [10:0] at,
  input  logic [10:0] bt,
  input  logic [10:0] ct,
  input  logic [10:0] applex,
  input  logic [10:0] bombx,
  input  logic [9:0]  appley,
  input  logic [9:0]  bomby,
  input  logic [10:0] pig,
  input  logic        eaten,
  input  logic [1:0]  state,
  input  logic        plusone,
  input  logic        clr,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic [15:0] score,
  output logic        frame_tick
);

  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;

  localparam logic [11:0] COL_PIG   = 12'hFAB;
  localparam logic [11:0] COL_BOMB  = 12'h222;
  localparam logic [11:0] COL_APPLE = 12'hF00;
  localparam logic [11:0] COL_WALL  = 12'hA50;
  localparam logic [11:0] COL_SKY   = 12'h08F;
  localparam logic [11:0] COL_OVER  = 12'h800;

  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;
  logic [15:0] score_q, score_d;
  logic        plus_q;

  logic [9:0]  ay_s, by_s, cy_s, appley_s, bomby_s;
  logic [10:0] at_s, bt_s, ct_s, applex_s, bombx_s, pig_s;
  logic        eaten_s;
  logic [1:0]  state_s;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  assign frame_tick = (hcnt_q == 10'd0) && (vcnt_q == 10'd480);

`ifdef SCENE_SNAPSHOT_EN
  logic [9:0]  ay_q, by_q, cy_q, appley_q, bomby_q;
  logic [10:0] at_q, bt_q, ct_q, applex_q, bombx_q, pig_q;
  logic        eaten_q;
  logic [1:0]  state_q;

  // Reset snapshot hides the apple until the first vblank capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ay_q <= '0; by_q <= '0; cy_q <= '0;
      at_q <= '0; bt_q <= '0; ct_q <= '0;
      applex_q <= '0; appley_q <= '0;
      bombx_q <= '0; bomby_q <= '0;
      pig_q <= '0; eaten_q <= 1'b1; state_q <= '0;
    end else if (frame_tick) begin
      ay_q <= ay; by_q <= by; cy_q <= cy;
      at_q <= at; bt_q <= bt; ct_q <= ct;
      applex_q <= applex; appley_q <= appley;
      bombx_q <= bombx; bomby_q <= bomby;
      pig_q <= pig; eaten_q <= eaten; state_q <= state;
    end
  end

  assign ay_s = ay_q;         assign by_s = by_q;         assign cy_s = cy_q;
  assign at_s = at_q;         assign bt_s = bt_q;         assign ct_s = ct_q;
  assign applex_s = applex_q; assign appley_s = appley_q;
  assign bombx_s = bombx_q;   assign bomby_s = bomby_q;
  assign pig_s = pig_q;       assign eaten_s = eaten_q;   assign state_s = state_q;
`else
  assign ay_s = ay;           assign by_s = by;           assign cy_s = cy;
  assign at_s = at;           assign bt_s = bt;           assign ct_s = ct;
  assign applex_s = applex;   assign appley_s = appley;
  assign bombx_s = bombx;     assign bomby_s = bomby;
  assign pig_s = pig;         assign eaten_s = eaten;     assign state_s = state;
`endif

  // 12-bit operands leave headroom so "+offset" bounds never wrap.
  function automatic logic inWall(input logic [11:0] x, input logic [11:0] y,
                                  input logic [9:0] wy, input logic [10:0] wt);
    logic [11:0] wy12, wt12;
    wy12 = {2'b00, wy};
    wt12 = {1'b0, wt};
    return (y >= wy12) && (y < wy12 + 12'd20) &&
           ((x <= wt12 + 12'd10) || (x >= wt12 + 12'd150));
  endfunction

  function automatic logic inBox(input logic [11:0] x, input logic [11:0] y,
                                 input logic [10:0] cx, input logic [9:0] top);
    logic [11:0] cx12, top12;
    cx12  = {1'b0, cx};
    top12 = {2'b00, top};
    return (x + 12'd8 >= cx12) && (x < cx12 + 12'd8) &&
           (y >= top12) && (y < top12 + 12'd16);
  endfunction

  logic [11:0] x12, y12;
  logic        visible, pigHit, bombHit, appleHit, wallHit;

  assign x12      = {2'b00, hcnt_q};
  assign y12      = {2'b00, vcnt_q};
  assign visible  = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
  assign pigHit   = (x12 + 12'd16 >= {1'b0, pig_s}) && (x12 < {1'b0, pig_s} + 12'd16) &&
                    (y12 >= 12'd384) && (y12 < 12'd416);
  assign bombHit  = inBox(x12, y12, bombx_s, bomby_s);
  assign appleHit = inBox(x12, y12, applex_s, appley_s) && !eaten_s;
  assign wallHit  = inWall(x12, y12, ay_s, at_s) || inWall(x12, y12, by_s, bt_s) ||
                    inWall(x12, y12, cy_s, ct_s);

  always_comb begin
    rgb_d = 12'h000;
    if (visible) begin
      if (pigHit)        rgb_d = COL_PIG;
      else if (bombHit)  rgb_d = COL_BOMB;
      else if (appleHit) rgb_d = COL_APPLE;
      else if (wallHit)  rgb_d = COL_WALL;
      else               rgb_d = (state_s == 2'd2) ? COL_OVER : COL_SKY;
    end
    hs_d = !((hcnt_q >= 10'd656) && (hcnt_q <= 10'd751));
    vs_d = !((vcnt_q >= 10'd490) && (vcnt_q <= 10'd491));
  end

  // Ripple BCD increment; clear wins over a coincident edge.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    score_d = score_q;
    carry   = 1'b1;
    dig     = 4'd0;
    if (clr) begin
      score_d = 16'h0000;
    end else if (plusone && !plus_q && (state == 2'd1)) begin
      for (int i = 0; i < 4; i++) begin
        dig = score_q[4*i +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            dig = 4'd0;
          end else begin
            dig   = dig + 4'd1;
            carry = 1'b0;
          end
        end
        score_d[4*i +: 4] = dig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= 12'h000;
      score_q <= 16'h0000;
      plus_q  <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      score_q <= score_d;
      plus_q  <= plusone;
    end
  end

  assign hs    = hs_q;
  assign vs    = vs_q;
  assign r     = rgb_q[11:8];
  assign g     = rgb_q[7:4];
  assign b     = rgb_q[3:0];
  assign score = score_q;

endmodule

// File: tb/tb_scene_render.sv
// Randomized scoreboard bench for scene_render: a pixel/score reference model
// predicts every output cycle; a monitor pops and compares after each clock edge.
module tb_scene_render;

  localparam int NCYC = 94000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  ay, by, cy, appley, bomby;
  logic [10:0] at, bt, ct, applex, bombx, pig;
  logic        eaten, plusone, clr;
  logic [1:0]  state;
  logic        hs, vs, frame_tick;
  logic [3:0]  r, g, b;
  logic [15:0] score;

  scene_render dut (
    .clk(clk), .rst_n(rst_n),
    .ay(ay), .by(by), .cy(cy),
    .at(at), .bt(bt), .ct(ct),
    .applex(applex), .bombx(bombx), .appley(appley), .bomby(bomby),
    .pig(pig), .eaten(eaten), .state(state),
    .plusone(plusone), .clr(clr),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .score(score), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  typedef struct {
    int ay, by, cy, at, bt, ct, ax, bx, apy, bmy, pig, st;
    bit eaten;
  } scene_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        ft;
    logic [15:0] score;
  } exp_t;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_hs"}, 32'(hs), 32'h1);
    checkOutput({tag, "_vs"}, 32'(vs), 32'h1);
    checkOutput({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
    checkOutput({tag, "_score"}, 32'(score), 32'h0);
    checkOutput({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  task automatic applyStimulus(input scene_t s);
    ay = 10'(s.ay);   by = 10'(s.by);   cy = 10'(s.cy);
    at = 11'(s.at);   bt = 11'(s.bt);   ct = 11'(s.ct);
    applex = 11'(s.ax);  appley = 10'(s.apy);
    bombx  = 11'(s.bx);  bomby  = 10'(s.bmy);
    pig = 11'(s.pig); eaten = s.eaten; state = 2'(s.st);
  endtask

  function automatic bit inWall(int x, int y, int wy, int wt);
    return (y >= wy) && (y < wy + 20) && ((x <= wt + 10) || (x >= wt + 150));
  endfunction

  function automatic bit inBox(int x, int y, int cx, int top, int halfW, int h);
    return (x >= cx - halfW) && (x < cx + halfW) && (y >= top) && (y < top + h);
  endfunction

  function automatic logic [11:0] refPixel(scene_t s, int x, int y);
    if (x >= 640 || y >= 480) return 12'h000;
    if (inBox(x, y, s.pig, 384, 16, 32)) return 12'hFAB;
    if (inBox(x, y, s.bx, s.bmy, 8, 16)) return 12'h222;
    if (!s.eaten && inBox(x, y, s.ax, s.apy, 8, 16)) return 12'hF00;
    if (inWall(x, y, s.ay, s.at) || inWall(x, y, s.by, s.bt) || inWall(x, y, s.cy, s.ct))
      return 12'hA50;
    return (s.st == 2) ? 12'h800 : 12'h08F;
  endfunction

  function automatic logic [15:0] toBcd(int v);
    logic [15:0] d;
    d[15:12] = 4'((v / 1000) % 10);
    d[11:8]  = 4'((v / 100) % 10);
    d[7:4]   = 4'((v / 10) % 10);
    d[3:0]   = 4'(v % 10);
    return d;
  endfunction

  function automatic int nearY(int base);
    int v;
    if ($urandom_range(7) == 0) return 600;
    v = base + 4 - int'($urandom_range(28));
    return (v < 0) ? 0 : v;
  endfunction

  function automatic scene_t randScene(int baseY, scene_t prev, bit randState);
    scene_t s;
    s.ay  = nearY(baseY);  s.by  = nearY(baseY);  s.cy  = nearY(baseY);
    s.at  = int'($urandom_range(700)); s.bt = int'($urandom_range(700));
    s.ct  = int'($urandom_range(700));
    s.ax  = int'($urandom_range(660)); s.bx = int'($urandom_range(660));
    s.apy = nearY(baseY);  s.bmy = nearY(baseY);
    s.pig = int'($urandom_range(2047));
    s.eaten = bit'($urandom_range(1));
    s.st  = randState ? int'($urandom_range(3)) : prev.st;
    return s;
  endfunction

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = '{hs: hs, vs: vs, rgb: {r, g, b}, ft: frame_tick, score: score};
        checkOutput("cycle_outputs", 32'(a), 32'(e));
      end
    end
  end

  initial begin : driver
    scene_t cur, snap, rs;
    int     tx, ty, nx, ny, scoreM;
    bit     prevPlus, inRst;
    exp_t   e;

    cur = '{default: 0};
    cur.ay = 600; cur.by = 600; cur.cy = 600; cur.apy = 600; cur.bmy = 600;
    cur.st = 1;
    snap = '{default: 0};
    snap.eaten = 1'b1;
    applyStimulus(cur);
    plusone = 1'b0;
    clr     = 1'b0;

    #5 rst_n = 1'b0;
    #1 checkReset("reset_initial");

    tx = 0; ty = 0; scoreM = 0; prevPlus = 1'b0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      if (n == 40)    checkOutput("score_after_3_pulses", 32'(score), 32'h0003);
      if (n == 20100) checkOutput("score_after_wrap_run", 32'(score), 32'h0033);
      if (n == 20103) checkOutput("score_clr_beats_pulse", 32'(score), 32'h0000);

      inRst = (n < 10) || (n >= 60000 && n < 60003);
      if (tx == 0 && (ty % 2) == 0) cur = randScene(ty, cur, n >= 20104);
      if (n < 20104) cur.st = 1;

      if (n < 10) begin
        plusone = 1'b0; clr = 1'b0;
      end else if (n < 40) begin
        plusone = ((n - 10) % 10) < 5; clr = 1'b0;
      end else if (n < 20100) begin
        plusone = (n % 2) == 1; clr = 1'b0;
      end else if (n < 20104) begin
        plusone = (n == 20101); clr = (n == 20101);
      end else begin
        plusone = bit'($urandom_range(1));
        clr     = ($urandom_range(99) == 0);
      end
      applyStimulus(cur);
      rst_n = !inRst;

      if (inRst) begin
        if (n == 60000) begin
          #1 checkReset("reset_midframe");
        end
        tx = 0; ty = 0; scoreM = 0; prevPlus = 1'b0;
        snap = '{default: 0};
        snap.eaten = 1'b1;
        e = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000, ft: 1'b0, score: 16'h0000};
      end else begin
`ifdef SCENE_SNAPSHOT_EN
        rs = snap;
`else
        rs = cur;
`endif
        e.rgb = refPixel(rs, tx, ty);
        e.hs  = !(tx >= 656 && tx <= 751);
        e.vs  = !(ty >= 490 && ty <= 491);
        nx = (tx + 1) % 800;
        ny = (tx == 799) ? (ty + 1) % 525 : ty;
        e.ft = (nx == 0) && (ny == 480);
        if (clr) scoreM = 0;
        else if (cur.st == 1 && plusone && !prevPlus) scoreM = (scoreM + 1) % 10000;
        prevPlus = plusone;
        e.score = toBcd(scoreM);
        if (tx == 0 && ty == 480) snap = cur;
        tx = nx; ty = ny;
      end
      expQ.push_back(e);
    end

    repeat (2) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
